// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcodes, FSM states and control-word encodings for the multicycle controller
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
  } ctrl_t;
endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: controller <-> datapath bundle (opcode/handshake in, control word out)
interface multicycle_control_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 32
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALUOP_W-1:0]  alu_op;
  logic [1:0]          pc_src;
  logic                pc_write;
  logic                pc_write_cond;
  logic                err_illegal;
  logic [CNT_W-1:0]    instr_count;
  modport master (
    input  opcode, mem_ready,
    output iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_write, pc_write_cond,
           err_illegal, instr_count
  );
  modport slave (
    output opcode, mem_ready,
    input  iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, pc_write, pc_write_cond,
           err_illegal, instr_count
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: state -> control word, with memory-strobe gating and strobes killed during reset
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   rst,
  output ctrl_t  ctrl
);
  logic go;
  logic en;
  assign en = ~rst;
  assign go = mem_ready & en;
  // Moore decode; only the memory-handshake strobes look at mem_ready
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.ir_write  = go;
        ctrl.pc_write  = go;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMMSH;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = en;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = go;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = en;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_src        = PC_ALUOUT;
        ctrl.pc_write_cond = en;
      end
      S_ADDIWB: ctrl.reg_write = en;
      S_JUMP: begin
        ctrl.pc_src   = PC_JUMP;
        ctrl.pc_write = en;
      end
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS main controller (state register, sequencing, sticky error, retire counter)
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 2,
  parameter int CNT_W       = 32,
  parameter int ENABLE_ADDI = 1,
  parameter int ENABLE_JUMP = 1
) (
  input logic clk,
  input logic rst,
  multicycle_control_if.master bus
);
  state_t state;
  state_t nxt;
  ctrl_t ctrl;
  logic [CNT_W-1:0] cnt;
  logic err;
  logic is_r, is_lw, is_sw, is_beq, is_addi, is_j;
  logic illegal, retire;
  assign is_r    = bus.opcode == OPCODE_W'(OP_RTYPE);
  assign is_lw   = bus.opcode == OPCODE_W'(OP_LW);
  assign is_sw   = bus.opcode == OPCODE_W'(OP_SW);
  assign is_beq  = bus.opcode == OPCODE_W'(OP_BEQ);
  assign is_addi = bus.opcode == OPCODE_W'(OP_ADDI) && ENABLE_ADDI != 0;
  assign is_j    = bus.opcode == OPCODE_W'(OP_J) && ENABLE_JUMP != 0;
  // Sequencing; unknown encodings fall back to FETCH
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:  nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: nxt = is_r ? S_EXEC : (is_lw || is_sw) ? S_MEMADR : is_beq ? S_BRANCH :
                      is_addi ? S_ADDIEX : is_j ? S_JUMP : S_FETCH;
      S_MEMADR: nxt = is_lw ? S_MEMRD : is_sw ? S_MEMWR : S_FETCH;
      S_MEMRD:  nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt = S_ALUWB;
      S_ADDIEX: nxt = S_ADDIWB;
      default:  nxt = S_FETCH;
    endcase
  end
  assign illegal = state == S_DECODE && nxt == S_FETCH;
  assign retire  = state inside {S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP} ||
                   (state == S_MEMWR && bus.mem_ready);
  // State register, sticky illegal flag and retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (illegal) err <= 1'b1;
      if (retire) cnt <= cnt + CNT_W'(1);
    end
  end
  mc_ctrl_decode u_dec (
    .state(state),
    .mem_ready(bus.mem_ready),
    .rst(rst),
    .ctrl(ctrl)
  );
  assign bus.iord          = ctrl.iord;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ALUOP_W'(ctrl.alu_op);
  assign bus.pc_src        = ctrl.pc_src;
  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.err_illegal   = err;
  assign bus.instr_count   = cnt;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-cycle scoreboard check of the multicycle controller
module tb_multicycle_control;
  // control word: iord mem_read mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a alu_src_b alu_op pc_src pc_write pc_write_cond
  localparam logic [15:0] F1   = 16'b0_1_0_1_0_0_0_0_01_00_00_1_0;
  localparam logic [15:0] F0   = 16'b0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [15:0] DEC  = 16'b0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [15:0] MADR = 16'b0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [15:0] MRD  = 16'b1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [15:0] MWB  = 16'b0_0_0_0_0_1_1_0_00_00_00_0_0;
  localparam logic [15:0] MWR0 = 16'b1_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [15:0] MWR1 = 16'b1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [15:0] EXE  = 16'b0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [15:0] AWB  = 16'b0_0_0_0_1_0_1_0_00_00_00_0_0;
  localparam logic [15:0] BR   = 16'b0_0_0_0_0_0_0_1_00_01_01_0_1;
  localparam logic [15:0] AIW  = 16'b0_0_0_0_0_0_1_0_00_00_00_0_0;
  localparam logic [15:0] JMP  = 16'b0_0_0_0_0_0_0_0_00_00_10_1_0;
  typedef struct {
    string      tag;
    logic [20:0] v;
  } exp_t;
  logic clk;
  logic rst;
  int n_cmp;
  int n_bad;
  exp_t q[$];
  multicycle_control_if #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(4)) bus ();
  multicycle_control #(.CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step(input string tag, input logic r, input logic [5:0] op, input logic mr,
                      input logic [15:0] c, input logic e, input logic [3:0] n);
    exp_t x;
    rst = r;
    bus.opcode = op;
    bus.mem_ready = mr;
    x.tag = tag;
    x.v = {c, e, n};
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t x;
      logic [20:0] act;
      x = q.pop_front();
      act = {bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
             bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src, bus.pc_write,
             bus.pc_write_cond, bus.err_illegal, bus.instr_count};
      n_cmp++;
      if (act !== x.v) begin
        n_bad++;
        $display("FAIL %s: got %b want %b", x.tag, act, x.v);
      end
    end
  end
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.opcode = 6'd0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step("reset", 1, 0, 1, F0, 0, 0);
    step("r_fetch", 0, 0, 1, F1, 0, 0);
    step("r_decode", 0, 0, 1, DEC, 0, 0);
    step("r_exec", 0, 0, 1, EXE, 0, 0);
    step("r_aluwb", 0, 0, 1, AWB, 0, 0);
    step("lw_fetch", 0, 35, 1, F1, 0, 1);
    step("lw_decode", 0, 35, 1, DEC, 0, 1);
    step("lw_memadr", 0, 35, 1, MADR, 0, 1);
    step("lw_memrd_w1", 0, 35, 0, MRD, 0, 1);
    step("lw_memrd_w2", 0, 35, 0, MRD, 0, 1);
    step("lw_memrd", 0, 35, 1, MRD, 0, 1);
    step("lw_memwb", 0, 35, 1, MWB, 0, 1);
    step("sw_fetch", 0, 43, 1, F1, 0, 2);
    step("sw_decode", 0, 43, 1, DEC, 0, 2);
    step("sw_memadr", 0, 43, 1, MADR, 0, 2);
    step("sw_memwr_w", 0, 43, 0, MWR0, 0, 2);
    step("sw_memwr", 0, 43, 1, MWR1, 0, 2);
    step("beq_fetch_w", 0, 4, 0, F0, 0, 3);
    step("beq_fetch", 0, 4, 1, F1, 0, 3);
    step("beq_decode", 0, 4, 1, DEC, 0, 3);
    step("beq_branch", 0, 4, 1, BR, 0, 3);
    step("j_fetch", 0, 2, 1, F1, 0, 4);
    step("j_decode", 0, 2, 1, DEC, 0, 4);
    step("j_jump", 0, 2, 1, JMP, 0, 4);
    step("addi_fetch", 0, 8, 1, F1, 0, 5);
    step("addi_decode", 0, 8, 1, DEC, 0, 5);
    step("addi_ex", 0, 8, 1, MADR, 0, 5);
    step("addi_wb", 0, 8, 1, AIW, 0, 5);
    step("ill_fetch", 0, 63, 1, F1, 0, 6);
    step("ill_decode", 0, 63, 1, DEC, 0, 6);
    step("ill_next_fetch", 0, 0, 1, F1, 1, 6);
    step("ill_r_decode", 0, 0, 1, DEC, 1, 6);
    step("ill_r_exec", 0, 0, 1, EXE, 1, 6);
    step("ill_r_aluwb", 0, 0, 1, AWB, 1, 6);
    step("rsw_fetch", 0, 43, 1, F1, 1, 7);
    step("rsw_decode", 0, 43, 1, DEC, 1, 7);
    step("rsw_memadr", 0, 43, 1, MADR, 1, 7);
    step("rsw_memwr_w", 0, 43, 0, MWR0, 1, 7);
    step("rsw_rst", 1, 43, 1, F0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step("wrap_fetch", 0, 2, 1, F1, 0, 4'(i));
      step("wrap_decode", 0, 2, 1, DEC, 0, 4'(i));
      step("wrap_jump", 0, 2, 1, JMP, 0, 4'(i));
    end
    step("wrap_zero", 0, 2, 1, F1, 0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
